// File: rtl/scalar_pc_sequencer.sv
// Scalar fetch sequencer: one instruction in flight; FETCH->WAIT_MEM->ISSUE->RESOLVE, 4 cycles per instruction with zero waits.
// Backpressure: holds in WAIT_MEM until IMEM_VALID, in ISSUE until INSTR_READY, in RESOLVE until BR_VALID/END_PGM.
module scalar_pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   START,
  input  logic [PC_WIDTH-1:0]    START_PC,
  output logic                   IMEM_REQ,
  output logic [PC_WIDTH-1:0]    IMEM_ADDR,
  input  logic                   IMEM_VALID,
  input  logic [INSTR_WIDTH-1:0] IMEM_DATA,
  output logic                   INSTR_VALID,
  output logic [INSTR_WIDTH-1:0] INSTR_OUT,
  output logic [PC_WIDTH-1:0]    INSTR_PC,
  input  logic                   INSTR_READY,
  input  logic                   BR_VALID,
  input  logic                   BR_TAKEN,
  input  logic [PC_WIDTH-1:0]    BR_OFFSET,
  input  logic                   END_PGM,
  output logic                   SET_PC,
  output logic [PC_WIDTH-1:0]    PC_NEXT,
  output logic                   BUSY,
  output logic                   DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_RESOLVE,
    S_HALT
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] resolved_pc;

  // Offset is already PC_WIDTH wide, so plain modular addition gives the sign-extended wrap.
  assign seq_pc      = pc + PC_WIDTH'(1);
  assign resolved_pc = seq_pc + (BR_TAKEN ? BR_OFFSET : '0);

  assign IMEM_ADDR = pc;
  assign INSTR_PC  = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      IMEM_REQ    <= 1'b0;
      INSTR_VALID <= 1'b0;
      INSTR_OUT   <= '0;
      SET_PC      <= 1'b0;
      PC_NEXT     <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      IMEM_REQ <= 1'b0;
      SET_PC   <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (START) begin
            state    <= S_FETCH;
            pc       <= START_PC;
            PC_NEXT  <= START_PC;
            SET_PC   <= 1'b1;
            IMEM_REQ <= 1'b1;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (IMEM_VALID) begin
            state       <= S_ISSUE;
            INSTR_OUT   <= IMEM_DATA;
            INSTR_VALID <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (INSTR_READY) begin
            state       <= S_RESOLVE;
            INSTR_VALID <= 1'b0;
          end
        end
        S_RESOLVE: begin
          // End of program wins over a same-cycle branch report.
          if (END_PGM) begin
            state <= S_HALT;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (BR_VALID) begin
            state    <= S_FETCH;
            pc       <= resolved_pc;
            PC_NEXT  <= resolved_pc;
            SET_PC   <= 1'b1;
            IMEM_REQ <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          INSTR_VALID <= 1'b0;
          BUSY        <= 1'b0;
          DONE        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/scalar_pc_sequencer.md
Name: scalar_pc_sequencer

Overview:
Instruction-fetch sequencer for the scalar unit. It owns the wavefront program counter, fetches one instruction at a time from instruction memory, and hands each instruction to the decoder. It waits for branch/end resolution from the SALU, then drives a load pulse and next-PC value into the PC register. Single outstanding instruction, no prefetch.

Parameters:
PC_WIDTH, 8, program counter width in instruction words
INSTR_WIDTH, 32, instruction word width

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
START  input  1  one-cycle pulse; begin wavefront at START_PC
START_PC  input  PC_WIDTH  entry address
IMEM_REQ  output  1  fetch request, one-cycle pulse
IMEM_ADDR  output  PC_WIDTH  fetch address, equals current PC
IMEM_VALID  input  1  instruction data valid
IMEM_DATA  input  INSTR_WIDTH  returned instruction
INSTR_VALID  output  1  instruction available to decoder
INSTR_OUT  output  INSTR_WIDTH  captured instruction
INSTR_PC  output  PC_WIDTH  address of INSTR_OUT
INSTR_READY  input  1  decoder accepts instruction
BR_VALID  input  1  SALU resolution of issued instruction; non-branches report TAKEN=0
BR_TAKEN  input  1  branch taken
BR_OFFSET  input  PC_WIDTH  signed two's-complement word offset
END_PGM  input  1  issued instruction is s_endpgm
SET_PC  output  1  load pulse to PC register
PC_NEXT  output  PC_WIDTH  value loaded when SET_PC=1
BUSY  output  1  wavefront executing
DONE  output  1  wavefront ended; held until restart

Behaviour:
- reset=1: state IDLE, internal pc=0; every output 0 (IMEM_ADDR, INSTR_OUT, INSTR_PC, PC_NEXT included). Reset overrides all inputs. Reset in any state aborts the operation. Any in-flight IMEM_VALID after reset is ignored.
- Moore outputs: IMEM_REQ=(FETCH), INSTR_VALID=(ISSUE), BUSY=(FETCH|WAIT_MEM|ISSUE|RESOLVE), DONE=(HALT), IMEM_ADDR=INSTR_PC=pc.
- SET_PC/PC_NEXT are registered. SET_PC is high exactly one cycle: the first cycle of FETCH after each PC load. PC_NEXT holds its last value otherwise.
- IDLE: START=1 -> pc<=START_PC, go FETCH.
- HALT: START=1 -> pc<=START_PC, go FETCH (relaunch); otherwise stay.
- START in FETCH/WAIT_MEM/ISSUE/RESOLVE is ignored.
- FETCH: lasts exactly 1 cycle -> WAIT_MEM.
- WAIT_MEM: IMEM_VALID=1 -> INSTR_OUT<=IMEM_DATA, go ISSUE. IMEM_VALID is ignored in all other states. IMEM_VALID may arrive any cycle after the request (minimum 1 cycle).
- ISSUE: INSTR_VALID=1 and INSTR_OUT/INSTR_PC stay stable until INSTR_READY=1. On handshake go RESOLVE.
- RESOLVE: wait for END_PGM or BR_VALID.
  - END_PGM=1 -> HALT. No SET_PC. pc is unchanged. END_PGM has priority when it arrives in the same cycle as BR_VALID.
  - BR_VALID=1 -> next = BR_TAKEN ? pc+1+sext(BR_OFFSET) : pc+1. The result is truncated to PC_WIDTH (wraps modulo 2^PC_WIDTH in both directions). pc<=next, go FETCH.
  - BR_VALID/END_PGM outside RESOLVE are ignored.
- Zero-wait throughput: 4 cycles per instruction (FETCH, WAIT_MEM, ISSUE, RESOLVE), when IMEM_VALID, INSTR_READY and BR_VALID each arrive on the first cycle of their state.
- START to first IMEM_REQ: 1 cycle.
- Non-taken branches and ordinary instructions are identical: pc+1.

Test Plan:
- Reset then START with START_PC=0x10 -> next cycle IMEM_REQ=1, IMEM_ADDR=0x10, SET_PC=1, PC_NEXT=0x10, BUSY=1. All outputs are 0 during reset.
- Straight-line code at 0x10 with zero-wait responses and BR_VALID/TAKEN=0 -> fetches 0x11, 0x12 at exactly 4-cycle spacing, INSTR_PC matches.
- Taken branch at pc=0x20 with BR_OFFSET=0xFC (-4) -> PC_NEXT=0x1D. At pc=0xFE with offset 0x05 -> PC_NEXT=0x04 (wrap). Non-taken branch at 0xFF -> PC_NEXT=0x00.
- INSTR_READY held low 5 cycles and IMEM_VALID delayed 3 cycles -> INSTR_VALID/INSTR_OUT stable throughout, no extra IMEM_REQ, single issue per instruction. IMEM_VALID pulses during ISSUE are ignored.
- END_PGM and BR_VALID=1/TAKEN=1 in same RESOLVE cycle -> HALT, DONE=1, BUSY=0, no SET_PC. Later START with START_PC=0x40 -> relaunch fetch at 0x40.
- reset asserted in WAIT_MEM, then IMEM_VALID arrives -> state IDLE, INSTR_VALID stays 0, no fetch until new START. START asserted mid-RESOLVE is ignored.
